// File: rtl/edsac_order_pkg.sv
// Shared constants, field map, FSM states and bit-order helpers
// for the Order Tank serial-to-parallel order decoder.
package edsac_order_pkg;

   localparam int ORDER_WIDTH = 18;

   localparam int OPC_LSB   = 13;
   localparam int OPC_MSB   = 17;
   localparam int SPARE_BIT = 12;
   localparam int TANK_LSB  = 7;
   localparam int TANK_MSB  = 11;
   localparam int POS_LSB   = 3;
   localparam int POS_MSB   = 6;
   localparam int HALF_BIT  = 2;
   localparam int LONG_BIT  = 1;

   localparam int OPC_W  = OPC_MSB - OPC_LSB + 1;
   localparam int TANK_W = TANK_MSB - TANK_LSB + 1;
   localparam int POS_W  = POS_MSB - POS_LSB + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_e;

   // The lowest-numbered order bit of a field is its MSB, so every
   // multi-bit field is bit-reversed relative to the serial word.
   function automatic logic [4:0] rev5(input logic [4:0] v);
      rev5 = {v[0], v[1], v[2], v[3], v[4]};
   endfunction

   function automatic logic [3:0] rev4(input logic [3:0] v);
      rev4 = {v[0], v[1], v[2], v[3]};
   endfunction

endpackage

// File: rtl/order_shift_reg.sv
// Serial-in/parallel-out word shifter with a bit counter.
// Ports: clk, rst, start_i (load bit 0, restart count), shift_i
// (shift one bit), bit_i (serial data), word_o (word including the
// bit currently on bit_i), done_o (bit_i is the last bit of a word).
module order_shift_reg #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic         shift_i,
   input  logic         bit_i,
   output logic [W-1:0] word_o,
   output logic         done_o
);

   localparam logic [4:0] LAST = 5'(W - 1);
   localparam logic [4:0] END  = 5'(W);

   logic [W-1:0] sh_q, sh_d;
   logic [4:0]   cnt_q, cnt_d;
   logic         active;
   logic         unused_lsb;

   // Counting stops at END, so a finished word never shifts again
   // until the next restart.
   assign active = (cnt_q != 5'd0) && (cnt_q < END);

   // New bits enter at the MSB: after W shifts bit i sits at index i.
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (start_i) begin
         sh_d  = {bit_i, {(W-1){1'b0}}};
         cnt_d = 5'd1;
      end else if (shift_i && active) begin
         sh_d  = {bit_i, sh_q[W-1:1]};
         cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= 5'd0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

   assign word_o     = {bit_i, sh_q[W-1:1]};
   assign done_o     = shift_i && !start_i && (cnt_q == LAST);
   assign unused_lsb = sh_q[0];

endmodule

// File: rtl/order_decoder.sv
// Captures one word-aligned order during Stage 2, splits it into
// static fields and checks recirculated copies against it.
// Ports: clk, rst, order/word_sync (serial tank output), g13 (Stage 2),
// order_clr; outputs opcode, spare, tank_num, position, half_mc,
// long_order, order_strobe, order_valid, sync_err, order_err.
module order_decoder
   import edsac_order_pkg::*;
#(
   parameter int WORD_WIDTH   = 18,
   parameter int RECIRC_CHECK = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       order,
   input  logic       word_sync,
   input  logic       g13,
   input  logic       order_clr,
   output logic [4:0] opcode,
   output logic       spare,
   output logic [4:0] tank_num,
   output logic [3:0] position,
   output logic       half_mc,
   output logic       long_order,
   output logic       order_strobe,
   output logic       order_valid,
   output logic       sync_err,
   output logic       order_err
);

   state_e              state_q;
   logic [OPC_W-1:0]    opc_q;
   logic                spare_q;
   logic [TANK_W-1:0]   tank_q;
   logic [POS_W-1:0]    pos_q;
   logic                half_q;
   logic                long_q;
   logic                valid_q;
   logic                err_q;
   logic                strobe_q;
   logic                serr_q;

   logic [ORDER_WIDTH-1:0] word_w;
   logic [ORDER_WIDTH-1:1] held_w;
   logic                   start_w;
   logic                   shift_w;
   logic                   done_w;
   logic                   unused_bit0;

   // A word_sync in Stage 2 always restarts the shifter: a new capture
   // in IDLE, a resync in SHIFT, a recirculation check in HOLD.
   assign start_w = g13 && word_sync && !order_clr;
   assign shift_w = g13 && !word_sync && !order_clr
                    && (state_q != IDLE);

   order_shift_reg #(
      .W(WORD_WIDTH)
   ) u_shift (
      .clk    (clk),
      .rst    (rst),
      .start_i(start_w),
      .shift_i(shift_w),
      .bit_i  (order),
      .word_o (word_w),
      .done_o (done_w)
   );

   assign held_w = {rev5(opc_q), spare_q, rev5(tank_q),
                    rev4(pos_q), half_q, long_q};

   assign unused_bit0 = word_w[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         opc_q    <= '0;
         spare_q  <= 1'b0;
         tank_q   <= '0;
         pos_q    <= '0;
         half_q   <= 1'b0;
         long_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         strobe_q <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         serr_q   <= 1'b0;
         if (order_clr) begin
            state_q <= IDLE;
            opc_q   <= '0;
            spare_q <= 1'b0;
            tank_q  <= '0;
            pos_q   <= '0;
            half_q  <= 1'b0;
            long_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (g13 && word_sync)
                     state_q <= SHIFT;
               end
               SHIFT: begin
                  if (!g13) begin
                     state_q <= IDLE;
                  end else if (word_sync) begin
                     serr_q <= 1'b1;
                  end else if (done_w) begin
                     opc_q    <= rev5(word_w[OPC_MSB:OPC_LSB]);
                     spare_q  <= word_w[SPARE_BIT];
                     tank_q   <= rev5(word_w[TANK_MSB:TANK_LSB]);
                     pos_q    <= rev4(word_w[POS_MSB:POS_LSB]);
                     half_q   <= word_w[HALF_BIT];
                     long_q   <= word_w[LONG_BIT];
                     valid_q  <= 1'b1;
                     strobe_q <= 1'b1;
                     state_q  <= HOLD;
                  end
               end
               HOLD: begin
                  if (!g13) begin
                     state_q <= IDLE;
                  end else if (RECIRC_CHECK != 0 && done_w
                               && word_w[ORDER_WIDTH-1:1] != held_w) begin
                     err_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign opcode       = opc_q;
   assign spare        = spare_q;
   assign tank_num     = tank_q;
   assign position     = pos_q;
   assign half_mc      = half_q;
   assign long_order   = long_q;
   assign order_strobe = strobe_q;
   assign order_valid  = valid_q;
   assign sync_err     = serr_q;
   assign order_err    = err_q;

endmodule

// File: tb/tb_order_decoder.sv
// Directed self-checking bench for order_decoder: capture, recirculation
// check, resync, abort, clear priority and mid-capture reset.
module tb_order_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       order;
   logic       word_sync;
   logic       g13;
   logic       order_clr;
   logic [4:0] opcode;
   logic       spare;
   logic [4:0] tank_num;
   logic [3:0] position;
   logic       half_mc;
   logic       long_order;
   logic       order_strobe;
   logic       order_valid;
   logic       sync_err;
   logic       order_err;

   int errors = 0;
   int checks = 0;

   // Serial words: index i is the bit sent i cycles after word_sync.
   localparam logic [17:0] W1 = 18'b101010011010101010;
   localparam logic [17:0] W2 = 18'b101101110000110101;
   // Hand-decoded {opcode, spare, tank_num, position, half, long}.
   localparam logic [16:0] F1 = {5'b10101, 1'b0, 5'b10110,
                                 4'b1010, 1'b0, 1'b1};
   localparam logic [16:0] F2 = {5'b01101, 1'b1, 5'b00011,
                                 4'b0110, 1'b1, 1'b0};

   logic [16:0] fields;
   logic [3:0]  flags;
   assign fields = {opcode, spare, tank_num, position,
                    half_mc, long_order};
   assign flags  = {order_strobe, order_valid, sync_err, order_err};

   order_decoder #(
      .WORD_WIDTH  (18),
      .RECIRC_CHECK(1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .order       (order),
      .word_sync   (word_sync),
      .g13         (g13),
      .order_clr   (order_clr),
      .opcode      (opcode),
      .spare       (spare),
      .tank_num    (tank_num),
      .position    (position),
      .half_mc     (half_mc),
      .long_order  (long_order),
      .order_strobe(order_strobe),
      .order_valid (order_valid),
      .sync_err    (sync_err),
      .order_err   (order_err)
   );

   always #5 clk = ~clk;

   task automatic step(input logic b, input logic ws);
      order     = b;
      word_sync = ws;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [17:0] w, input int first,
                            input int n, output int ns, output int ne);
      ns = 0;
      ne = 0;
      for (int i = first; i < first + n; i++) begin
         step(w[i], i == 0);
         ns += int'(order_strobe);
         ne += int'(sync_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      checks++;
      if (fields !== 17'h0) begin
         errors++;
         $display("FAIL reset_fields got=%h exp=0", fields);
      end
      checks++;
      if (flags !== 4'h0) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=0000", flags);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int ns, ne;
      g13 = 1'b1;
      send_word(W1, 0, 18, ns, ne);
      checks++;
      if (order_strobe !== 1'b1) begin
         errors++;
         $display("FAIL basic_strobe got=%b exp=1", order_strobe);
      end
      checks++;
      if (ns !== 1) begin
         errors++;
         $display("FAIL basic_strobe_cnt got=%0d exp=1", ns);
      end
      checks++;
      if (order_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_valid got=%b exp=1", order_valid);
      end
      checks++;
      if (fields !== F1) begin
         errors++;
         $display("FAIL basic_fields got=%h exp=%h", fields, F1);
      end
   endtask

   task automatic test_recirc();
      int ns, ne, tot;
      logic [17:0] bad;
      tot = 0;
      for (int k = 0; k < 3; k++) begin
         send_word(W1, 0, 18, ns, ne);
         tot += ns;
      end
      checks++;
      if (tot !== 0) begin
         errors++;
         $display("FAIL recirc_strobe got=%0d exp=0", tot);
      end
      checks++;
      if (order_err !== 1'b0) begin
         errors++;
         $display("FAIL recirc_err_clean got=%b exp=0", order_err);
      end
      bad = W1;
      bad[9] = ~bad[9];
      send_word(bad, 0, 18, ns, ne);
      checks++;
      if (order_err !== 1'b1) begin
         errors++;
         $display("FAIL recirc_err_set got=%b exp=1", order_err);
      end
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
      checks++;
      if (order_err !== 1'b1) begin
         errors++;
         $display("FAIL recirc_err_sticky got=%b exp=1", order_err);
      end
      checks++;
      if (fields !== F1) begin
         errors++;
         $display("FAIL recirc_fields_frozen got=%h exp=%h", fields, F1);
      end
      order_clr = 1'b1;
      step(1'b0, 1'b0);
      order_clr = 1'b0;
      checks++;
      if (fields !== 17'h0 || flags !== 4'h0) begin
         errors++;
         $display("FAIL recirc_clr got=%h/%b exp=0/0000", fields, flags);
      end
   endtask

   task automatic test_resync();
      int ns, ne, ns0, ne0;
      send_word(W1, 0, 7, ns0, ne0);
      send_word(W2, 0, 18, ns, ne);
      checks++;
      if (ne !== 1 || ne0 !== 0) begin
         errors++;
         $display("FAIL resync_serr got=%0d/%0d exp=0/1", ne0, ne);
      end
      checks++;
      if (order_strobe !== 1'b1 || ns !== 1 || ns0 !== 0) begin
         errors++;
         $display("FAIL resync_strobe got=%b cnt=%0d exp=1 cnt=1",
                  order_strobe, ns);
      end
      checks++;
      if (fields !== F2) begin
         errors++;
         $display("FAIL resync_fields got=%h exp=%h", fields, F2);
      end
   endtask

   task automatic test_abort();
      int ns, ne, ns2, tot;
      g13 = 1'b0;
      step(1'b0, 1'b0);
      g13 = 1'b1;
      send_word(W1, 0, 10, ns, ne);
      g13 = 1'b0;
      send_word(W1, 10, 8, ns2, ne);
      tot = ns + ns2;
      checks++;
      if (tot !== 0) begin
         errors++;
         $display("FAIL abort_strobe got=%0d exp=0", tot);
      end
      checks++;
      if (fields !== F2 || order_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_keep got=%h v=%b exp=%h v=1",
                  fields, order_valid, F2);
      end
      send_word(W1, 0, 18, ns, ne);
      checks++;
      if (ns !== 0 || fields !== F2) begin
         errors++;
         $display("FAIL abort_nog13 got=%0d/%h exp=0/%h", ns, fields, F2);
      end
      g13 = 1'b1;
      send_word(W1, 0, 18, ns, ne);
      checks++;
      if (ns !== 1 || order_strobe !== 1'b1 || fields !== F1) begin
         errors++;
         $display("FAIL abort_recapture got=%0d/%h exp=1/%h",
                  ns, fields, F1);
      end
   endtask

   task automatic test_priority();
      int ns, ne, ns2;
      g13 = 1'b0;
      step(1'b0, 1'b0);
      g13 = 1'b1;
      send_word(W2, 0, 17, ns, ne);
      order_clr = 1'b1;
      step(W2[17], 1'b0);
      order_clr = 1'b0;
      checks++;
      if (order_strobe !== 1'b0 || ns !== 0) begin
         errors++;
         $display("FAIL prio_strobe got=%b exp=0", order_strobe);
      end
      checks++;
      if (fields !== 17'h0 || order_valid !== 1'b0) begin
         errors++;
         $display("FAIL prio_fields got=%h v=%b exp=0 v=0",
                  fields, order_valid);
      end
      send_word(W1, 0, 18, ns, ne);
      checks++;
      if (fields !== F1 || order_valid !== 1'b1) begin
         errors++;
         $display("FAIL prio_after_clr got=%h exp=%h", fields, F1);
      end
      g13 = 1'b0;
      step(1'b0, 1'b0);
      g13 = 1'b1;
      send_word(W2, 0, 9, ns, ne);
      rst = 1'b1;
      step(W2[9], 1'b0);
      rst = 1'b0;
      checks++;
      if (fields !== 17'h0 || flags !== 4'h0) begin
         errors++;
         $display("FAIL rst_mid got=%h/%b exp=0/0000", fields, flags);
      end
      send_word(W2, 10, 8, ns, ne);
      send_word(W2, 1, 17, ns2, ne);
      checks++;
      if (ns + ns2 !== 0 || order_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_nocapture got=%0d v=%b exp=0 v=0",
                  ns + ns2, order_valid);
      end
      send_word(W2, 0, 18, ns, ne);
      checks++;
      if (ns !== 1 || fields !== F2) begin
         errors++;
         $display("FAIL rst_recapture got=%0d/%h exp=1/%h",
                  ns, fields, F2);
      end
   endtask

   initial begin
      rst       = 1'b1;
      order     = 1'b0;
      word_sync = 1'b0;
      g13       = 1'b0;
      order_clr = 1'b0;
      test_reset();
      test_basic();
      test_recirc();
      test_resync();
      test_abort();
      test_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/order_decoder.md
Name: order_decoder

Overview:
Serial-to-parallel reader at the output end of the Order Tank. During Stage 2 of main control it captures one word-aligned 18-bit order from the tank's serial output and splits it into static fields for the Tank Decoders, Coincidence Unit and opcode decoder. While Stage 2 persists it also checks each recirculated copy against the held order. Sits between the Order Tank and the main-control decode logic.

Parameters:
WORD_WIDTH, 18, bits per order (minor cycle); fixed field map requires 18
RECIRC_CHECK, 1, 1 enables comparison of recirculated copies in HOLD

Ports:
clk  in  1  system clock; one bit-time per cycle
rst  in  1  synchronous, active-high reset
order  in  1  serial order bit from the Order Tank, bit 0 first
word_sync  in  1  high on the cycle carrying bit 0 of each minor cycle
g13  in  1  Stage 2 of main control
order_clr  in  1  end-of-Stage-2 clear
opcode  out  5  order bits 13-17
spare  out  1  order bit 12
tank_num  out  5  order bits 7-11
position  out  4  order bits 3-6
half_mc  out  1  order bit 2
long_order  out  1  order bit 1
order_strobe  out  1  one-cycle pulse: fields newly valid
order_valid  out  1  level: fields hold a complete order
sync_err  out  1  one-cycle pulse: word_sync arrived mid-capture
order_err  out  1  sticky: recirculated copy differs from held order

Behaviour:
- Bit i arrives i cycles after the word_sync cycle. Within each field, the lowest-numbered order bit is the MSB. Bit 0 is captured but discarded.
- Reset:
  - State = IDLE.
  - All field outputs, order_valid and order_err = 0.
  - order_strobe and sync_err = 0.
- States:
  - IDLE: wait for g13 & word_sync. On that cycle shift bit 0 in, set bit_cnt = 1, go to SHIFT.
  - SHIFT: shift order in each cycle and increment bit_cnt.
    - When the bit at bit_cnt = 17 is shifted in, register all fields on the next edge, pulse order_strobe for one cycle with order_valid rising on the same cycle, and go to HOLD. Latency is 18 cycles from the word_sync cycle to order_strobe.
    - If word_sync arrives while bit_cnt is 1..17: pulse sync_err, treat the cycle as bit 0 of a new capture (bit_cnt = 1) and discard partial bits.
    - If g13 falls: abort to IDLE; fields and order_valid are unchanged.
  - HOLD: fields are frozen. Recapture never occurs, even though the tank keeps recirculating.
    - If RECIRC_CHECK = 1, each word starting at word_sync is compared bit-by-bit, bits 1-17, against the held order. Any mismatch sets order_err, which stays set until order_clr or rst.
    - g13 falling moves the block to IDLE with fields retained. A later Stage 2 recaptures and overwrites them.
- order_clr, any state, synchronous:
  - Clears fields, order_valid and order_err; state goes to IDLE.
  - order_clr has priority over completion in the same cycle: no strobe, and fields stay 0.
- rst overrides everything, including mid-capture. After reset, a capture starts only on the next word_sync.
- word_sync without g13 is ignored in IDLE.

Decomposition:
- Package edsac_order_pkg holds:
  - ORDER_WIDTH = 18.
  - Field LSB/MSB constants: OPC 13-17, SPARE 12, TANK 7-11, POS 3-6, HALF 2, LONG 1.
  - Field width constants.
  - FSM state enum {IDLE, SHIFT, HOLD}.
- One sub-module, order_shift_reg: an 18-bit serial-in/parallel-out shift register with a 5-bit bit counter, load/restart control and a done flag.
- The FSM, field slicing and recirculation compare stay in order_decoder.

Test Plan:
1. Basic capture: g13 = 1, word_sync at t0, serial 0,1,0,1010,10110,0,10101 (bits 0-17). Required at t0 + 18: order_strobe pulses; order_valid = 1; opcode = 5'b10101; spare = 0; tank_num = 5'b10110; position = 4'b1010; half_mc = 0; long_order = 1.
2. Recirculation: stay in HOLD for 3 identical words → no further strobe, order_err = 0. Corrupt bit 9 of the 4th word → order_err = 1 until order_clr, then all outputs = 0.
3. Resync: extra word_sync at bit_cnt = 7 → sync_err pulses. Fields then match the word that starts at the second word_sync, with order_strobe 18 cycles after it.
4. Abort: g13 falls at bit 10 → no strobe; prior fields and order_valid are unchanged; state is IDLE. A new Stage 2 plus word_sync captures normally.
5. Priority: order_clr on the completion cycle → no strobe, fields = 0. rst asserted mid-SHIFT → all outputs 0, and no capture until the next g13 & word_sync.
